ita_output_credit_fifo: RTL and testbench

Credit-managed output buffer directly downstream of the requantizer. It accepts one `requant_oup_t` vector (N signed WI-bit results) per cycle without backpressure and buffers it in a FifoDepth-entry first-in-first-out store. It emits packed `fifo_data_t` words over a valid/ready handshake. An ongoing-operation counter stalls the issuing controller so that buffer overflow is impossible in correct operation.

---
 rtl/ita_package.sv | 20 ++
 rtl/ita_ring_buffer.sv | 79 +++++++
 rtl/ita_output_credit_fifo.sv | 95 +++++++++
 tb/tb_ita_output_credit_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_package.sv
// Shared types and sizing for the ITA output path.
// Result vectors, packed FIFO words and the counter widths of the output buffer.
package ita_package;

  localparam int unsigned N         = 16;
  localparam int unsigned WI        = 8;
  localparam int unsigned FifoDepth = 12;

  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

  localparam int unsigned OutFifoPtrWidth = idx_width(FifoDepth);

  typedef logic signed [N-1:0][WI-1:0]         requant_oup_t;
  typedef logic [N*WI-1:0]                     fifo_data_t;
  typedef logic [idx_width(FifoDepth+1)-1:0]   fifo_usage_t;
  typedef logic [idx_width(FifoDepth+1)-1:0]   ongoing_t;

endpackage

// File: rtl/ita_ring_buffer.sv
// Circular store with explicit pointer wrap, full/empty and an occupancy count.
// A push into a full buffer is accepted only when a pop frees the head in the same cycle.
module ita_ring_buffer
  import ita_package::*;
#(
  parameter int unsigned Depth = 12,
  parameter int unsigned Width = 128,
  localparam int unsigned PtrW = idx_width(Depth),
  localparam int unsigned CntW = idx_width(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CntW-1:0]  o_usage,
  output logic             o_drop
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_usage;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PtrW-1:0]  w_wptr_nxt;
  logic [PtrW-1:0]  w_rptr_nxt;

  assign w_full    = (r_usage == CntW'(Depth));
  assign w_empty   = (r_usage == '0);
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Depth need not be a power of two, so the wrap is an explicit compare.
  assign w_wptr_nxt = (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
  assign w_rptr_nxt = (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (!i_flush && w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usage <= '0;
    end else begin
      if (w_push_ok) r_wptr <= w_wptr_nxt;
      if (w_pop_ok)  r_rptr <= w_rptr_nxt;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_usage <= r_usage + CntW'(1);
        2'b01:   r_usage <= r_usage - CntW'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_usage = r_usage;
  assign o_drop  = i_push && w_full && !w_pop_ok;

endmodule

// File: rtl/ita_output_credit_fifo.sv
// Credit-managed output buffer behind the requantizer: ring buffer plus an
// issued-but-not-popped counter that stalls the controller before overflow.
module ita_output_credit_fifo
  import ita_package::*;
#(
  parameter int unsigned FifoDepth = ita_package::FifoDepth,
  parameter int unsigned N         = ita_package::N,
  parameter int unsigned WI        = ita_package::WI
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         issue_i,
  output logic         stall_o,
  input  logic         valid_i,
  input  requant_oup_t data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output fifo_data_t   data_o,
  output fifo_usage_t  usage_o,
  output ongoing_t     ongoing_o,
  output logic         err_o
);

  ongoing_t    r_ongoing;
  logic        r_err;

  fifo_data_t  w_packed;
  fifo_data_t  w_head;
  fifo_usage_t w_usage;
  logic        w_empty;
  logic        w_full;
  logic        w_drop;
  logic        w_stall;
  logic        w_issue_ok;
  logic        w_pop;
  logic        w_underflow;
  logic        w_orphan;
  logic        w_err_evt;

  always_comb begin
    w_packed = '0;
    for (int n = 0; n < N; n++) w_packed[n*WI +: WI] = data_i[n];
  end

  ita_ring_buffer #(
    .Depth (FifoDepth),
    .Width ($bits(fifo_data_t))
  ) u_ring (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_flush (flush_i),
    .i_push  (valid_i),
    .i_pop   (w_pop),
    .i_data  (w_packed),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_usage (w_usage),
    .o_drop  (w_drop)
  );

  assign w_stall     = (r_ongoing == ongoing_t'(FifoDepth));
  assign w_issue_ok  = issue_i && !w_stall;
  assign w_pop       = !w_empty && ready_i;
  assign w_underflow = w_pop && !w_issue_ok && (r_ongoing == '0);
  // A result with every issued credit already matched by a stored entry has no owner.
  assign w_orphan    = valid_i && (r_ongoing == ongoing_t'(w_usage));
  assign w_err_evt   = (issue_i && w_stall) || w_drop || w_underflow || w_orphan;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ongoing <= '0;
      r_err     <= 1'b0;
    end else if (flush_i) begin
      r_ongoing <= '0;
      r_err     <= 1'b0;
    end else begin
      case ({w_issue_ok, w_pop})
        2'b10:   r_ongoing <= r_ongoing + ongoing_t'(1);
        2'b01:   if (!w_underflow) r_ongoing <= r_ongoing - ongoing_t'(1);
        default: r_ongoing <= r_ongoing;
      endcase
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign stall_o   = w_stall;
  assign valid_o   = !w_empty;
  assign data_o    = w_head;
  assign usage_o   = w_usage;
  assign ongoing_o = r_ongoing;
  assign err_o     = r_err;

endmodule

// File: tb/tb_ita_output_credit_fifo.sv
// Directed bench for ita_output_credit_fifo: a vector table for basic handshakes
// plus hand-written sequences for fill/stall, reset, packing, wrap and flush.
module tb_ita_output_credit_fifo;
  import ita_package::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i, issue_i, valid_i, ready_i;
  requant_oup_t data_i;
  logic         stall_o, valid_o, err_o;
  fifo_data_t   data_o;
  fifo_usage_t  usage_o;
  ongoing_t     ongoing_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  ita_output_credit_fifo dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .issue_i   (issue_i),
    .stall_o   (stall_o),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .usage_o   (usage_o),
    .ongoing_o (ongoing_o),
    .err_o     (err_o)
  );

  typedef struct {
    logic       issue, valid, ready, flush;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_head;
    int         exp_usage, exp_ongoing;
    logic       exp_stall, exp_err;
  } vec_t;

  vec_t vecs [7];

  function automatic fifo_data_t rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iss, input logic vld, input logic [7:0] b,
                       input logic rdy, input logic fl);
    issue_i = iss;
    valid_i = vld;
    data_i  = requant_oup_t'(rep(b));
    ready_i = rdy;
    flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_flush();
    drive(0, 0, 8'h00, 0, 1);
    tick();
    drive(0, 0, 8'h00, 0, 0);
  endtask

  // k issues, each result one cycle after its issue
  task automatic issue_and_fill(input int k);
    for (int i = 0; i < k; i++) begin
      drive(1, i > 0, 8'(i), 0, 0);
      tick();
    end
    drive(0, 1, 8'(k), 0, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    fifo_data_t exp_q [$];
    fifo_data_t w;
    fifo_data_t pk;
    int issued, sent, recv;
    logic iss, vld, rdy;

    vecs[0] = '{1,0,0,0, 8'h00, 0, 8'h00, 0, 1, 0, 0};
    vecs[1] = '{1,0,0,0, 8'h00, 0, 8'h00, 0, 2, 0, 0};
    vecs[2] = '{0,1,0,0, 8'hA1, 1, 8'hA1, 1, 2, 0, 0};
    vecs[3] = '{0,1,1,0, 8'hA2, 1, 8'hA2, 1, 1, 0, 0};
    vecs[4] = '{0,0,1,0, 8'h00, 0, 8'h00, 0, 0, 0, 0};
    vecs[5] = '{0,1,0,0, 8'h55, 1, 8'h55, 1, 0, 0, 1};
    vecs[6] = '{1,1,0,1, 8'h66, 0, 8'h00, 0, 0, 0, 0};

    rst_ni = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid",   128'(valid_o),   128'(0));
    chk("rst_stall",   128'(stall_o),   128'(0));
    chk("rst_usage",   128'(usage_o),   128'(0));
    chk("rst_ongoing", 128'(ongoing_o), 128'(0));
    chk("rst_err",     128'(err_o),     128'(0));
    chk("rst_data",    data_o,          128'(0));
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].issue, vecs[i].valid, vecs[i].din, vecs[i].ready, vecs[i].flush);
      tick();
      chk($sformatf("vec%0d_valid", i),   128'(valid_o),   128'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_usage", i),   128'(usage_o),   128'(vecs[i].exp_usage));
      chk($sformatf("vec%0d_ongoing", i), 128'(ongoing_o), 128'(vecs[i].exp_ongoing));
      chk($sformatf("vec%0d_stall", i),   128'(stall_o),   128'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_err", i),     128'(err_o),     128'(vecs[i].exp_err));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_head", i), data_o, rep(vecs[i].exp_head));
    end
    drive(0, 0, 8'h00, 0, 0);

    // fill to 12 and stall
    for (int i = 0; i < 12; i++) begin
      drive(1, i > 0, 8'(i), 0, 0);
      tick();
    end
    chk("fill_stall_after_12", 128'(stall_o), 128'(1));
    chk("fill_ongoing_12", 128'(ongoing_o), 128'(12));
    drive(0, 1, 8'h0C, 0, 0);
    tick();
    chk("fill_usage_12", 128'(usage_o), 128'(12));
    chk("fill_err_clear", 128'(err_o), 128'(0));
    drive(1, 0, 8'h00, 0, 0);
    tick();
    chk("issue13_err", 128'(err_o), 128'(1));
    chk("issue13_ongoing", 128'(ongoing_o), 128'(12));
    drive(0, 1, 8'hEE, 0, 0);
    tick();
    chk("drop_usage", 128'(usage_o), 128'(12));
    chk("full_head_01", data_o, rep(8'h01));
    drive(0, 1, 8'h0D, 1, 0);
    tick();
    chk("fullpp_usage", 128'(usage_o), 128'(12));
    chk("fullpp_ongoing", 128'(ongoing_o), 128'(11));
    for (int j = 2; j <= 12; j++) begin
      chk($sformatf("drain_%0d", j), data_o, rep(8'(j)));
      chk($sformatf("drain_valid_%0d", j), 128'(valid_o), 128'(1));
      drive(0, 0, 8'h00, 1, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0);
    chk("drain_last_0D", data_o, rep(8'h0D));
    chk("drain_usage", 128'(usage_o), 128'(1));
    chk("drain_ongoing", 128'(ongoing_o), 128'(0));
    do_flush();

    // reset mid-stream with usage 5
    issue_and_fill(5);
    chk("pre_rst_usage", 128'(usage_o), 128'(5));
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid",   128'(valid_o),   128'(0));
    chk("mid_rst_usage",   128'(usage_o),   128'(0));
    chk("mid_rst_ongoing", 128'(ongoing_o), 128'(0));
    chk("mid_rst_data",    data_o,          128'(0));
    #2;
    rst_ni = 1'b1;
    drive(1, 0, 8'h00, 0, 0);
    tick();
    chk("post_rst_empty", 128'(valid_o), 128'(0));
    drive(0, 1, 8'h77, 0, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0);
    chk("post_rst_valid", 128'(valid_o), 128'(1));
    chk("post_rst_data", data_o, rep(8'h77));
    do_flush();

    // packing: lane n = n-8
    for (int n = 0; n < 16; n++) pk[n*8 +: 8] = 8'(n - 8);
    drive(1, 0, 8'h00, 0, 0);
    tick();
    issue_i = 0;
    valid_i = 1;
    data_i  = requant_oup_t'(pk);
    tick();
    drive(0, 0, 8'h00, 0, 0);
    chk("pack_lane0", 128'(data_o[7:0]), 128'(8'hF8));
    chk("pack_lane15", 128'(data_o[127:120]), 128'(8'h07));
    chk("pack_word", data_o, pk);
    do_flush();

    // wrap-around stream of 40 vectors
    issued = 0; sent = 0; recv = 0;
    for (int cyc = 0; cyc < 800 && recv < 40; cyc++) begin
      iss = (issued < 40) && !stall_o;
      vld = (issued > sent) && ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      if (valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          chk("wrap_unexpected_pop", 128'(1), 128'(0));
        end else begin
          chk($sformatf("wrap_data_%0d", recv), data_o, exp_q[0]);
          void'(exp_q.pop_front());
        end
        recv++;
      end
      issue_i = iss;
      valid_i = vld;
      ready_i = rdy;
      flush_i = 0;
      if (vld) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        data_i = requant_oup_t'(w);
        exp_q.push_back(w);
        sent++;
      end
      tick();
      if (iss) issued++;
    end
    drive(0, 0, 8'h00, 0, 0);
    chk("wrap_received", 128'(recv), 128'(40));
    chk("wrap_err", 128'(err_o), 128'(0));
    chk("wrap_usage", 128'(usage_o), 128'(0));
    chk("wrap_ongoing", 128'(ongoing_o), 128'(0));

    // flush with usage 7, ongoing 9, err set, plus same-cycle push
    issue_and_fill(7);
    drive(0, 1, 8'h99, 0, 0);
    tick();
    drive(0, 0, 8'h00, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h00, 0, 0);
      tick();
    end
    chk("preflush_usage", 128'(usage_o), 128'(7));
    chk("preflush_ongoing", 128'(ongoing_o), 128'(9));
    chk("preflush_err", 128'(err_o), 128'(1));
    drive(1, 1, 8'h42, 1, 1);
    tick();
    drive(0, 0, 8'h00, 0, 0);
    chk("flush_usage", 128'(usage_o), 128'(0));
    chk("flush_ongoing", 128'(ongoing_o), 128'(0));
    chk("flush_err", 128'(err_o), 128'(0));
    chk("flush_valid", 128'(valid_o), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
